// File: rtl/div_share_arbiter_pkg.sv
// Shared types for the divider-sharing arbiter: FSM state, owner encoding and default width.
package div_share_arbiter_pkg;

    localparam int unsigned DIV_W = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef enum logic {
        OwnerLine1 = 1'b0,
        OwnerLine2 = 1'b1
    } owner_e;

endpackage

// File: rtl/div_reuse_entry.sv
// Single-entry memo of the last completed divide; hit_o flags an exact operand match.
module div_reuse_entry
    import div_share_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic              wr_signed_i,
    input  logic [DATA_W-1:0] wr_dividend_i,
    input  logic [DATA_W-1:0] wr_divisor_i,
    input  logic [DATA_W-1:0] wr_quotient_i,
    input  logic [DATA_W-1:0] wr_remainder_i,
    input  logic              lk_signed_i,
    input  logic [DATA_W-1:0] lk_dividend_i,
    input  logic [DATA_W-1:0] lk_divisor_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o
);

    logic              valid_q;
    logic              signed_q;
    logic [DATA_W-1:0] dividend_q;
    logic [DATA_W-1:0] divisor_q;
    logic [DATA_W-1:0] quotient_q;
    logic [DATA_W-1:0] remainder_q;

    // Only reset invalidates; flush/cancel never reach this block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= 1'b0;
            signed_q    <= 1'b0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else if (wr_en_i) begin
            valid_q     <= 1'b1;
            signed_q    <= wr_signed_i;
            dividend_q  <= wr_dividend_i;
            divisor_q   <= wr_divisor_i;
            quotient_q  <= wr_quotient_i;
            remainder_q <= wr_remainder_i;
        end
    end

    assign hit_o = valid_q && (signed_q == lk_signed_i) && (dividend_q == lk_dividend_i) &&
                   (divisor_q == lk_divisor_i);
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;

endmodule

// File: rtl/div_share_arbiter.sv
// Arbitrates two requesting lines onto one shared divider (line1 has priority).
// Optional result reuse is enabled by defining DIV_RESULT_REUSE_EN.
module div_share_arbiter
    import div_share_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              line1_req_i,
    input  logic              line1_signed_i,
    input  logic [DATA_W-1:0] line1_dividend_i,
    input  logic [DATA_W-1:0] line1_divisor_i,
    input  logic              line1_ack_i,
    output logic              line1_done_o,
    output logic [DATA_W-1:0] line1_quotient_o,
    output logic [DATA_W-1:0] line1_remainder_o,
    input  logic              line2_req_i,
    input  logic              line2_signed_i,
    input  logic [DATA_W-1:0] line2_dividend_i,
    input  logic [DATA_W-1:0] line2_divisor_i,
    input  logic              line2_ack_i,
    output logic              line2_done_o,
    output logic [DATA_W-1:0] line2_quotient_o,
    output logic [DATA_W-1:0] line2_remainder_o,
    output logic              div_en_o,
    output logic              div_signed_o,
    output logic [DATA_W-1:0] div_dividend_o,
    output logic [DATA_W-1:0] div_divisor_o,
    output logic              div_rst_n_o,
    input  logic              div_finished_i,
    input  logic [DATA_W-1:0] div_quotient_i,
    input  logic [DATA_W-1:0] div_remainder_i
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              signed_q, signed_d;
    logic [DATA_W-1:0] dividend_q, dividend_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              div_en_q;

    logic              owner_req, owner_ack, abort;
    logic              req_signed;
    logic [DATA_W-1:0] req_dividend, req_divisor;
    logic              reuse_hit;
    logic [DATA_W-1:0] reuse_quot, reuse_rem;

    assign owner_req    = (owner_q == OwnerLine2) ? line2_req_i : line1_req_i;
    assign owner_ack    = (owner_q == OwnerLine2) ? line2_ack_i : line1_ack_i;
    assign req_signed   = line1_req_i ? line1_signed_i   : line2_signed_i;
    assign req_dividend = line1_req_i ? line1_dividend_i : line2_dividend_i;
    assign req_divisor  = line1_req_i ? line1_divisor_i  : line2_divisor_i;

`ifdef DIV_RESULT_REUSE_EN
    logic entry_wr;

    // Record only divides that genuinely complete, never aborted ones.
    assign entry_wr = (state_q == StRun) && !flush_i && owner_req && div_finished_i;

    div_reuse_entry #(
        .DATA_W(DATA_W)
    ) u_reuse_entry (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .wr_en_i       (entry_wr),
        .wr_signed_i   (signed_q),
        .wr_dividend_i (dividend_q),
        .wr_divisor_i  (divisor_q),
        .wr_quotient_i (div_quotient_i),
        .wr_remainder_i(div_remainder_i),
        .lk_signed_i   (req_signed),
        .lk_dividend_i (req_dividend),
        .lk_divisor_i  (req_divisor),
        .hit_o         (reuse_hit),
        .quotient_o    (reuse_quot),
        .remainder_o   (reuse_rem)
    );
`else
    assign reuse_hit  = 1'b0;
    assign reuse_quot = '0;
    assign reuse_rem  = '0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        signed_d   = signed_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        abort      = 1'b0;
        case (state_q)
            StIdle: begin
                if (!flush_i && (line1_req_i || line2_req_i)) begin
                    owner_d    = line1_req_i ? OwnerLine1 : OwnerLine2;
                    signed_d   = req_signed;
                    dividend_d = req_dividend;
                    divisor_d  = req_divisor;
                    if (reuse_hit) begin
                        quot_d  = reuse_quot;
                        rem_d   = reuse_rem;
                        state_d = StDone;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else if (!owner_req) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else if (div_finished_i) begin
                    quot_d  = div_quotient_i;
                    rem_d   = div_remainder_i;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (flush_i || owner_ack || !owner_req) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= OwnerLine1;
            signed_q   <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            signed_q   <= signed_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_en_q   <= (state_d == StRun);
        end
    end

    assign div_en_o       = div_en_q;
    assign div_signed_o   = signed_q;
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign div_rst_n_o    = rst_n & ~flush_i & ~abort;

    // Flush hides a completed result in the same cycle it is raised.
    assign line1_done_o      = (state_q == StDone) && !flush_i && (owner_q == OwnerLine1);
    assign line2_done_o      = (state_q == StDone) && !flush_i && (owner_q == OwnerLine2);
    assign line1_quotient_o  = quot_q;
    assign line1_remainder_o = rem_q;
    assign line2_quotient_o  = quot_q;
    assign line2_remainder_o = rem_q;

endmodule

// File: doc/div_share_arbiter.md
DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port flush_i, input, 1, exception flush; aborts all divide activity.
REQ-005 The block SHALL have ports lineN_req_i (N=1,2), input, 1, divide request, held high until done/ack or cancel.
REQ-006 The block SHALL have ports lineN_signed_i, input, 1, signed divide select.
REQ-007 The block SHALL have ports lineN_dividend_i and lineN_divisor_i, input, DATA_W, operands.
REQ-008 The block SHALL have ports lineN_ack_i, input, 1, the requesting stage advanced and consumed the result.
REQ-009 The block SHALL have ports lineN_done_o, output, 1, result valid for line N.
REQ-010 The block SHALL have ports lineN_quotient_o and lineN_remainder_o, output, DATA_W, result for line N.
REQ-011 The block SHALL have ports div_en_o, div_signed_o, div_dividend_o and div_divisor_o, output, 1/1/DATA_W/DATA_W, shared divider drive.
REQ-012 The block SHALL have port div_rst_n_o, output, 1, divider reset: rst_n AND NOT flush AND NOT abort pulse.
REQ-013 The block SHALL have ports div_finished_i, div_quotient_i and div_remainder_i, input, 1/DATA_W/DATA_W, divider completion and result.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE plus a 1-bit owner register (0=line1, 1=line2).
REQ-015 In IDLE, line1_req_i SHALL win over line2_req_i (line1 is the older instruction), and the grant SHALL latch the winner's sign/operands and move to RUN.
REQ-016 div_en_o SHALL be registered, high in every RUN cycle, low in IDLE/DONE; request seen in cycle t gives div_en_o high at t+1.
REQ-017 div_signed_o, div_dividend_o and div_divisor_o SHALL present the latched values, stable for the whole of RUN.
REQ-018 On div_finished_i in RUN, the block SHALL latch quotient/remainder and enter DONE the next cycle.
REQ-019 In DONE, lineN_done_o SHALL be 1 for the owner only; quotient/remainder SHALL be driven to both lines, with the non-owner's done at 0.
REQ-020 In DONE, owner ack SHALL return the FSM to IDLE and done SHALL drop the following cycle; a waiting line SHALL be granted no earlier than the cycle after that.
REQ-021 If the owner's req drops in RUN without ack (cancel), the block SHALL force div_rst_n_o low for exactly one cycle and return to IDLE; the same drop in DONE SHALL return to IDLE with no divider reset.
REQ-022 flush_i SHALL take priority over finished, ack and new requests; it SHALL mask done combinationally in the same cycle, force IDLE next cycle and hold div_rst_n_o low while asserted.
REQ-023 Signed/unsigned arithmetic and divide-by-zero results SHALL be whatever the divider returns, passed through unmodified.

Reset
REQ-024 Asynchronous reset SHALL force IDLE and owner=0, with all outputs 0 (results, done, div_en_o, divider operands), div_rst_n_o low, and the reuse entry invalid.

Configuration
REQ-025 With DIV_RESULT_REUSE_EN defined, the block SHALL keep the last completed {signed, dividend, divisor, quotient, remainder, valid}; a grant whose signed/dividend/divisor all match a valid entry SHALL go IDLE->DONE in one cycle with div_en_o never asserted.
REQ-026 The reuse entry SHALL be invalidated only by reset; flush and cancel SHALL NOT clear it, and an aborted divide SHALL NOT update it.
REQ-027 Without DIV_RESULT_REUSE_EN, every grant SHALL use the divider and no entry storage SHALL exist.

Structure
REQ-028 A shared package SHALL hold the state encoding, the owner encoding and DIV_W=32.
REQ-029 A single sub-module div_reuse_entry (compare plus storage) SHALL be instantiated only under DIV_RESULT_REUSE_EN.

Verification
REQ-030 Bench SHALL cover: line1 unsigned 100/7 alone -> div_en_o high at t+1, line1_done_o=1 the cycle after finished with q=14 and r=2, and held until ack.
REQ-031 Bench SHALL cover: both req same cycle, line1 signed -9/2, line2 unsigned 9/2 -> line1 served first (q=-4, r=-1), then line2 granted after line1 ack (q=4, r=1).
REQ-032 Bench SHALL cover: flush_i mid-RUN -> div_rst_n_o low that cycle, no done, IDLE next cycle, and a following request completes correctly.
REQ-033 Bench SHALL cover: line2 req drops in RUN -> one-cycle div_rst_n_o pulse, and a pending line1 request is then served.
REQ-034 Bench SHALL cover: DIV_RESULT_REUSE_EN, repeat 100/7 unsigned -> done one cycle after grant with div_en_o never high; a signed repeat misses and uses the divider.
REQ-035 Bench SHALL cover: rst_n asserted in DONE -> all outputs 0 immediately, and after release a new request completes.
